// File: rtl/palette_pkg.sv
// Shared palette definition for the 4-bit indexed frame store.
// The index-to-RGB converter decodes through the same table, so encode and decode stay consistent.
package palette_pkg;

  localparam int PAL_N  = 14;
  localparam int RGB_W  = 24;
  localparam int IDX_W  = 4;
  localparam int ADDR_W = 10;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_UP = 2'd1,
    WR_LO = 2'd2
  } state_e;

  localparam rgb_t PALETTE [0:PAL_N-1] = '{
    24'h000000, 24'h003366, 24'hFF0000, 24'hFF9F00,
    24'hFFFF00, 24'h33FF00, 24'h009BFF, 24'h6D33FF,
    24'hFFD393, 24'hFF99FF, 24'hFF329F, 24'h999999,
    24'hFF9999, 24'hFFFFFF
  };

  // Indices beyond the table (E, F) decode to black.
  function automatic rgb_t pal_decode(input idx_t idx);
    rgb_t rgb;
    rgb = 24'h000000;
    for (int k = 0; k < PAL_N; k++) begin
      rgb = (idx == idx_t'(k)) ? PALETTE[k] : rgb;
    end
    return rgb;
  endfunction

endpackage

// File: rtl/palette_match.sv
// Combinational exact-match lookup of one RGB pixel against the palette.
// Unmatched pixels return index 0 with miss set; 000000 is a genuine hit on index 0.
module palette_match
  import palette_pkg::*;
(
  input  rgb_t rgb_i,
  output idx_t idx_o,
  output logic miss_o
);

  logic [PAL_N-1:0] hit_s;
  idx_t             idx_s;

  // Palette entries are distinct, so at most one hit bit is set and OR-ing is an encoder.
  always_comb begin
    hit_s = '0;
    idx_s = '0;
    for (int k = 0; k < PAL_N; k++) begin
      hit_s[k] = (rgb_i == PALETTE[k]);
      idx_s    = idx_s | ({IDX_W{hit_s[k]}} & idx_t'(k));
    end
  end

  assign idx_o  = idx_s;
  assign miss_o = ~|hit_s;

endmodule

// File: rtl/palette_encode.sv
// Encodes two RGB pixels per input word into palette indices and writes them to the
// 2048x4 frame memory: upper pixel to {0,addr}, lower pixel to {1,addr}.
module palette_encode
  import palette_pkg::*;
#(
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        in_addr,
  input  logic [47:0]       in_data,
  output logic              wr_en,
  output logic [10:0]       wr_addr,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic [MISS_W-1:0] miss_count
);

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  idx_t                idx_up_q, idx_up_d;
  idx_t                idx_lo_q, idx_lo_d;
  logic [MISS_W-1:0]   miss_q, miss_d;

  idx_t                idx_up_s, idx_lo_s;
  logic                miss_up_s, miss_lo_s;
  logic                accept_s;
  logic [1:0]          miss_sum_s;
  logic [MISS_W:0]     miss_ext_s;
  logic [MISS_W-1:0]   miss_sat_s;

  palette_match u_match_up (
    .rgb_i  (in_data[47:24]),
    .idx_o  (idx_up_s),
    .miss_o (miss_up_s)
  );

  palette_match u_match_lo (
    .rgb_i  (in_data[23:0]),
    .idx_o  (idx_lo_s),
    .miss_o (miss_lo_s)
  );

  // Output decode from registered state only; nothing from in_* reaches wr_* here.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 11'd0;
    wr_data  = 4'd0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      WR_UP: begin
        wr_en   = 1'b1;
        wr_addr = {1'b0, addr_q};
        wr_data = idx_up_q;
        busy    = 1'b1;
      end
      WR_LO: begin
        in_ready = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = {1'b1, addr_q};
        wr_data  = idx_lo_q;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign accept_s   = in_valid & in_ready;
  assign miss_count = miss_q;

  // Saturating add of this word's misses; the extra top bit flags overflow.
  always_comb begin
    miss_sum_s = {1'b0, miss_up_s} + {1'b0, miss_lo_s};
    miss_ext_s = {1'b0, miss_q} + (MISS_W+1)'(miss_sum_s);
    if (miss_ext_s[MISS_W]) begin
      miss_sat_s = MISS_MAX;
    end else begin
      miss_sat_s = miss_ext_s[MISS_W-1:0];
    end
  end

  // Next-state and register-load logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    idx_up_d = idx_up_q;
    idx_lo_d = idx_lo_q;
    miss_d   = miss_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = WR_UP;
        end else begin
          state_d = IDLE;
        end
      end
      WR_UP: begin
        state_d = WR_LO;
      end
      WR_LO: begin
        if (accept_s) begin
          state_d = WR_UP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept_s) begin
      addr_d   = in_addr;
      idx_up_d = idx_up_s;
      idx_lo_d = idx_lo_s;
      miss_d   = miss_sat_s;
    end else begin
      miss_d   = miss_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      idx_up_q <= '0;
      idx_lo_q <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_up_q <= idx_up_d;
      idx_lo_q <= idx_lo_d;
      miss_q   <= miss_d;
    end
  end

endmodule

// File: tb/tb_palette_encode.sv
// Scoreboard bench for palette_encode: a default-width instance plus a MISS_W=2 instance for saturation.
module tb_palette_encode;
  import palette_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [9:0]  in_addr;
  logic [47:0] in_data;

  logic        in_ready, wr_en, busy;
  logic [10:0] wr_addr;
  logic [3:0]  wr_data;
  logic [7:0]  miss_count;

  logic        s_in_ready, s_wr_en, s_busy;
  logic [10:0] s_wr_addr;
  logic [3:0]  s_wr_data;
  logic [1:0]  s_miss_count;

  palette_encode dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .miss_count(miss_count)
  );

  palette_encode #(.MISS_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_addr(in_addr), .in_data(in_data), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .busy(s_busy), .miss_count(s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [23:0] TB_PAL [14] = '{
    24'h000000, 24'h003366, 24'hFF0000, 24'hFF9F00, 24'hFFFF00, 24'h33FF00, 24'h009BFF,
    24'h6D33FF, 24'hFFD393, 24'hFF99FF, 24'hFF329F, 24'h999999, 24'hFF9999, 24'hFFFFFF
  };

  typedef struct {
    logic [10:0] addr;
    logic [3:0]  data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cnt8 = 0;
  int  cnt2 = 0;
  time last_acc = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns {miss, index} from the bench's own copy of the palette.
  function automatic logic [4:0] ref_lookup(input logic [23:0] rgb);
    logic [4:0] r;
    r = {1'b1, 4'd0};
    for (int k = 0; k < 14; k++) begin
      if (rgb == TB_PAL[k]) r = {1'b0, 4'(k)};
    end
    return r;
  endfunction

  task automatic send(input logic [9:0] a, input logic [23:0] up, input logic [23:0] lo,
                      input bit chk_gap);
    int n;
    logic [4:0] ru, rl;
    int m;
    @(negedge clk);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = {up, lo};
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("ready_timeout", 48'd0, 48'd1);
    @(posedge clk);
    if (chk_gap) chk("accept_gap", 48'($time - last_acc), 48'd20);
    last_acc = $time;
    ru = ref_lookup(up);
    rl = ref_lookup(lo);
    sb.push_back('{addr: {1'b0, a}, data: ru[3:0]});
    sb.push_back('{addr: {1'b1, a}, data: rl[3:0]});
    m = int'(ru[4]) + int'(rl[4]);
    cnt8 = (cnt8 + m > 255) ? 255 : cnt8 + m;
    cnt2 = (cnt2 + m > 3) ? 3 : cnt2 + m;
  endtask

  task automatic go_idle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 48'hDEAD_BEEF_0000;
    repeat (cycles) @(negedge clk);
  endtask

  // Monitor: every cycle compares outputs against the scoreboard and model counters.
  always @(negedge clk) begin
    wr_t e;
    chk("in_ready", in_ready, sb.size() != 2);
    chk("busy", busy, sb.size() != 0);
    chk("miss8", miss_count, 48'(cnt8));
    chk("miss2", s_miss_count, 48'(cnt2));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("wr_en", wr_en, 48'd1);
      chk("wr_addr", wr_addr, e.addr);
      chk("wr_data", wr_data, e.data);
      chk("sat_wr_data", s_wr_data, e.data);
    end else begin
      chk("wr_en_idle", wr_en, 48'd0);
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_addr  = 10'd0;
    in_data  = 48'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_wr_addr", wr_addr, 48'd0);
    chk("rst_wr_data", wr_data, 48'd0);
    chk("rst_in_ready", in_ready, 48'd1);
    reset = 1'b0;

    // Single isolated word.
    send(10'h005, 24'hFF0000, 24'h009BFF, 1'b0);
    go_idle(2);
    #1;
    chk("single_idle_busy", busy, 48'd0);
    chk("single_miss", miss_count, 48'd0);

    // Back-to-back stream of four words.
    send(10'h010, 24'h003366, 24'hFFFFFF, 1'b0);
    send(10'h011, 24'hFF9F00, 24'h999999, 1'b1);
    send(10'h3FF, 24'h6D33FF, 24'hFF329F, 1'b1);
    send(10'h200, 24'h33FF00, 24'hFFD393, 1'b1);
    go_idle(3);

    // Misses.
    send(10'h020, 24'h123456, 24'h000000, 1'b0);
    go_idle(2);
    #1 chk("miss_after_1", miss_count, 48'd1);
    send(10'h021, 24'hABCDEF, 24'h010101, 1'b0);
    go_idle(2);
    #1 chk("miss_after_3", miss_count, 48'd3);

    // Saturation on the narrow counter from a clean start.
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    cnt8 = 0;
    cnt2 = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) send(10'(i + 10'h030), 24'h111111, 24'h222222, i != 0);
    go_idle(2);
    #1;
    chk("sat_max", s_miss_count, 48'd3);
    chk("sat_wide", miss_count, 48'd6);

    // Full sweep of the palette on both halves, back-to-back.
    for (int i = 0; i < 14; i++) send(10'(10'h100 + i), TB_PAL[i], TB_PAL[13 - i], i != 0);
    go_idle(3);
    for (int i = 0; i < 14; i++) chk("decode_roundtrip", pal_decode(4'(i)), TB_PAL[i]);

    // Reset during the upper write drops the lower write and clears the counter.
    send(10'h055, 24'h123456, 24'hFF0000, 1'b0);
    @(negedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    sb.delete();
    cnt8 = 0;
    cnt2 = 0;
    @(negedge clk);
    #1;
    chk("rst_mid_wr_en", wr_en, 48'd0);
    chk("rst_mid_ready", in_ready, 48'd1);
    chk("rst_mid_miss", miss_count, 48'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
